// File: rtl/apb_uart_master.sv
// APB requester fed by a small command FIFO: queued {write, addr, wdata} commands are
// issued as SETUP/ACCESS transfers, each finishing with a one-cycle response or a timeout abort.
module apb_uart_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic [31:0] PRDATA
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [64:0]   mem [FIFO_DEPTH];
    logic [64:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tcnt;
    logic          push;
    logic          pop;
    logic          done;
    logic          tmo;

    assign cmd_ready = (count < FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && PREADY;
    assign tmo       = (state == ACCESS) && !PREADY && (tcnt == TMO_LAST);
    // The FIFO is drained either from IDLE or straight out of a finishing ACCESS.
    assign pop       = (count != '0) && ((state == IDLE) || done || tmo);
    assign busy      = (state != IDLE) || (count != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            tcnt      <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWR       <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (done || tmo) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= PWR;
                        rsp_rdata <= (done && !PWR) ? PRDATA : '0;
                        rsp_err   <= tmo;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
            // Loading a new command overrides the ACCESS update; otherwise a finished transfer parks.
            if (pop) begin
                state   <= SETUP;
                tcnt    <= '0;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWR     <= head[64];
                PADDR   <= head[63:32];
                PWDATA  <= head[31:0];
            end else if (done || tmo) begin
                state   <= IDLE;
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                PWR     <= 1'b0;
                PADDR   <= '0;
                PWDATA  <= '0;
            end
        end
    end

endmodule
